// File: rtl/simon_control.sv
// Simon game control FSM: conditions the enter button, paces playback with a
// hold timer and drives the datapath select/step/write/clear controls.
module simon_control #(
  parameter int PLAY_TICKS = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       is_legal,
  input  logic       play_gt_count,
  input  logic       repeat_eq_play,
  input  logic       input_eq_pattern,
  output logic [1:0] select,
  output logic [2:0] mode_leds,
  output logic       clrcount,
  output logic       w_en
);

  localparam int            TW   = $clog2(PLAY_TICKS);
  localparam logic [TW-1:0] TERM = TW'(PLAY_TICKS - 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_INPUT  = 3'd1,
    S_PLAY   = 3'd2,
    S_REPEAT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          edge_q, edge_d;
  logic          press_q, press_d;
  logic          chk_q, chk_d;
  logic [1:0]    select_q, select_d;
  logic [2:0]    mode_q, mode_d;
  logic          clrcount_q, clrcount_d;
  logic          w_en_q, w_en_d;

  // Button synchronizer and rising-edge detector; press_q is a one-cycle pulse.
  always_comb begin
    sync1_d = valid;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    press_d = sync2_q & ~edge_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    chk_d      = 1'b0;
    mode_d     = 3'b000;
    clrcount_d = 1'b0;
    w_en_d     = 1'b0;
    select_d   = 2'b00;

    case (state_q)
      S_INIT: begin
        state_d = S_INPUT;
        mode_d  = 3'b001;
      end
      S_INPUT: begin
        if (press_q && is_legal) begin
          state_d = S_PLAY;
          w_en_d  = 1'b1;
          mode_d  = 3'b000;
        end else begin
          state_d = S_INPUT;
          mode_d  = 3'b001;
        end
      end
      S_PLAY: begin
        mode_d = (timer_q == '0) ? 3'b010 : 3'b000;
        if (timer_q == TERM) begin
          timer_d = '0;
          state_d = play_gt_count ? S_REPEAT : S_PLAY;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_REPEAT: begin
        // chk_q marks the cycle after a 100 step, once the datapath index has moved on.
        if (chk_q) begin
          if (!repeat_eq_play) begin
            state_d = S_INPUT;
            mode_d  = 3'b001;
          end else begin
            state_d = S_REPEAT;
          end
        end else if (press_q) begin
          if (input_eq_pattern) begin
            mode_d = 3'b100;
            chk_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_REPEAT;
        end
      end
      S_DONE: begin
        mode_d  = (timer_q == '0) ? 3'b111 : 3'b000;
        timer_d = (timer_q == TERM) ? '0 : timer_q + TW'(1);
      end
      default: begin
        state_d    = S_INIT;
        clrcount_d = 1'b1;
      end
    endcase

    case (state_d)
      S_REPEAT: select_d = 2'b01;
      S_DONE:   select_d = 2'b10;
      default:  select_d = 2'b00;
    endcase
  end

  // All state and output flops, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      timer_q    <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      press_q    <= 1'b0;
      chk_q      <= 1'b0;
      select_q   <= 2'b00;
      mode_q     <= 3'b000;
      clrcount_q <= 1'b1;
      w_en_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      press_q    <= press_d;
      chk_q      <= chk_d;
      select_q   <= select_d;
      mode_q     <= mode_d;
      clrcount_q <= clrcount_d;
      w_en_q     <= w_en_d;
    end
  end

  assign select    = select_q;
  assign mode_leds = mode_q;
  assign clrcount  = clrcount_q;
  assign w_en      = w_en_q;

endmodule

// File: tb/tb_simon_control.sv
// Bench for simon_control: directed vector table, held-button/async-reset
// sequences, then random stimulus against a phase-level reference model.
module tb_simon_control;

  localparam int PT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic       is_legal = 1'b0;
  logic       play_gt_count = 1'b0;
  logic       repeat_eq_play = 1'b0;
  logic       input_eq_pattern = 1'b0;
  logic [1:0] select;
  logic [2:0] mode_leds;
  logic       clrcount;
  logic       w_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simon_control #(.PLAY_TICKS(PT)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid            (valid),
    .is_legal         (is_legal),
    .play_gt_count    (play_gt_count),
    .repeat_eq_play   (repeat_eq_play),
    .input_eq_pattern (input_eq_pattern),
    .select           (select),
    .mode_leds        (mode_leds),
    .clrcount         (clrcount),
    .w_en             (w_en)
  );

  typedef struct {
    logic       v, lg, gt, rp, eq;
    logic [1:0] sel;
    logic [2:0] mode;
    logic       clr, wen;
  } vec_t;

  localparam logic [6:0] RESET_OUT = 7'b00_000_1_0;

  vec_t tbl[44];

  function automatic vec_t mk(logic v, logic lg, logic gt, logic rp, logic eq,
                              logic [1:0] s, logic [2:0] m, logic c, logic w);
    vec_t r;
    r.v = v; r.lg = lg; r.gt = gt; r.rp = rp; r.eq = eq;
    r.sel = s; r.mode = m; r.clr = c; r.wen = w;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {select, mode_leds, clrcount, w_en};
  endfunction

  // Reference model: game phases, with step pacing derived from edges since entry.
  localparam int P_INIT = 0, P_INPUT = 1, P_PLAY = 2, P_REP = 3, P_REPCHK = 4, P_DONE = 5;
  int         m_phase, m_start, m_edge;
  bit         m_v[$];
  logic [6:0] m_exp;

  task automatic model_reset();
    m_phase = P_INIT;
    m_edge  = 0;
    m_start = 0;
    m_v     = {};
    repeat (4) m_v.push_back(1'b0);
    m_exp   = RESET_OUT;
  endtask

  task automatic model_edge();
    bit         press;
    int         rel;
    logic [1:0] s;
    logic [2:0] m;
    logic       w;
    m_edge++;
    m_v.push_back(valid);
    // press acts three edges after valid is first sampled high
    press = m_v[m_v.size()-4] && !m_v[m_v.size()-5];
    if (m_v.size() > 8) void'(m_v.pop_front());
    m = 3'b000;
    w = 1'b0;
    rel = m_edge - m_start - 1;
    case (m_phase)
      P_INIT: begin m_phase = P_INPUT; m = 3'b001; end
      P_INPUT: begin
        m = 3'b001;
        if (press && is_legal) begin
          w = 1'b1; m = 3'b000; m_phase = P_PLAY; m_start = m_edge;
        end
      end
      P_PLAY: begin
        if (rel % PT == 0) m = 3'b010;
        if (rel % PT == PT - 1 && play_gt_count) m_phase = P_REP;
      end
      P_REP: begin
        if (press) begin
          if (input_eq_pattern) begin m = 3'b100; m_phase = P_REPCHK; end
          else begin m_phase = P_DONE; m_start = m_edge; end
        end
      end
      P_REPCHK: begin
        if (!repeat_eq_play) begin m_phase = P_INPUT; m = 3'b001; end
        else m_phase = P_REP;
      end
      P_DONE: begin
        if (rel % PT == 0) m = 3'b111;
      end
      default: ;
    endcase
    s = (m_phase == P_REP || m_phase == P_REPCHK) ? 2'b01 :
        (m_phase == P_DONE) ? 2'b10 : 2'b00;
    m_exp = {s, m, 1'b0, w};
  endtask

  task automatic tick_check(string name);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(name, outs(), m_exp);
  endtask

  initial begin
    int wen_cnt;
    // edges 1..44 after reset release; inputs {v,lg,gt,rp,eq}, outputs {sel,mode,clr,wen}
    tbl[0]  = mk(0,0,0,0,0, 2'b00,3'b001,0,0);
    tbl[1]  = mk(1,0,0,0,0, 2'b00,3'b001,0,0);
    tbl[2]  = mk(1,0,0,0,0, 2'b00,3'b001,0,0);
    tbl[3]  = mk(0,0,0,0,0, 2'b00,3'b001,0,0);
    tbl[4]  = mk(0,0,0,0,0, 2'b00,3'b001,0,0);
    tbl[5]  = mk(1,1,0,0,0, 2'b00,3'b001,0,0);
    tbl[6]  = mk(0,1,0,0,0, 2'b00,3'b001,0,0);
    tbl[7]  = mk(0,1,0,0,0, 2'b00,3'b001,0,0);
    tbl[8]  = mk(0,1,0,0,0, 2'b00,3'b000,0,1);
    tbl[9]  = mk(0,0,0,0,0, 2'b00,3'b010,0,0);
    tbl[10] = mk(0,0,0,0,0, 2'b00,3'b000,0,0);
    tbl[11] = mk(0,0,1,0,0, 2'b00,3'b000,0,0);
    tbl[12] = mk(0,0,1,0,0, 2'b01,3'b000,0,0);
    tbl[13] = mk(1,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[14] = mk(0,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[15] = mk(0,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[16] = mk(0,0,0,1,1, 2'b01,3'b100,0,0);
    tbl[17] = mk(0,0,0,0,0, 2'b00,3'b001,0,0);
    tbl[18] = mk(1,1,0,0,0, 2'b00,3'b001,0,0);
    tbl[19] = mk(0,1,0,0,0, 2'b00,3'b001,0,0);
    tbl[20] = mk(0,1,0,0,0, 2'b00,3'b001,0,0);
    tbl[21] = mk(0,1,0,0,0, 2'b00,3'b000,0,1);
    tbl[22] = mk(0,0,0,0,0, 2'b00,3'b010,0,0);
    tbl[23] = mk(0,0,0,0,0, 2'b00,3'b000,0,0);
    tbl[24] = mk(0,0,0,0,0, 2'b00,3'b000,0,0);
    tbl[25] = mk(0,0,1,0,0, 2'b01,3'b000,0,0);
    tbl[26] = mk(1,0,1,0,0, 2'b01,3'b000,0,0);
    tbl[27] = mk(0,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[28] = mk(0,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[29] = mk(0,0,0,0,1, 2'b01,3'b100,0,0);
    tbl[30] = mk(0,0,0,1,0, 2'b01,3'b000,0,0);
    tbl[31] = mk(1,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[32] = mk(0,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[33] = mk(0,0,0,0,0, 2'b01,3'b000,0,0);
    tbl[34] = mk(0,0,0,0,0, 2'b10,3'b000,0,0);
    tbl[35] = mk(1,1,0,0,1, 2'b10,3'b111,0,0);
    tbl[36] = mk(0,1,0,0,1, 2'b10,3'b000,0,0);
    tbl[37] = mk(0,0,0,0,0, 2'b10,3'b000,0,0);
    tbl[38] = mk(0,0,0,0,0, 2'b10,3'b000,0,0);
    tbl[39] = mk(0,0,0,0,0, 2'b10,3'b111,0,0);
    tbl[40] = mk(0,0,0,0,0, 2'b10,3'b000,0,0);
    tbl[41] = mk(0,0,0,0,0, 2'b10,3'b000,0,0);
    tbl[42] = mk(0,0,0,0,0, 2'b10,3'b000,0,0);
    tbl[43] = mk(0,0,0,0,0, 2'b10,3'b111,0,0);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), outs(), RESET_OUT);
    end
    rst = 1'b1;

    for (int i = 0; i < 44; i++) begin
      valid = tbl[i].v; is_legal = tbl[i].lg; play_gt_count = tbl[i].gt;
      repeat_eq_play = tbl[i].rp; input_eq_pattern = tbl[i].eq;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec_edge%0d", i + 1), outs(),
            {tbl[i].sel, tbl[i].mode, tbl[i].clr, tbl[i].wen});
    end

    // Async reset out of DONE, then a held button in INPUT.
    #2 rst = 1'b0;
    #1 check("async_rst_done", outs(), RESET_OUT);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    valid = 1'b1; is_legal = 1'b1; play_gt_count = 1'b0;
    repeat_eq_play = 1'b0; input_eq_pattern = 1'b0;
    wen_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick_check($sformatf("held%0d", i));
      if (w_en) wen_cnt++;
    end
    check("held_wen_count", wen_cnt, 1);
    valid = 1'b0;
    tick_check("play_a");
    tick_check("play_b");
    #2 rst = 1'b0;
    #1 check("async_rst_play", outs(), RESET_OUT);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Random stimulus against the model, with periodic asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 149) begin
        #2 rst = 1'b0;
        #1 check("rand_rst", outs(), RESET_OUT);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) valid = ~valid;
      is_legal         = 1'($urandom_range(0, 1));
      play_gt_count    = ($urandom_range(0, 2) == 0);
      repeat_eq_play   = 1'($urandom_range(0, 1));
      input_eq_pattern = ($urandom_range(0, 3) != 0);
      tick_check($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
